ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port `ram` block (combinational read, write on posedge clk when load=1).
- Shares the RAM between two requesters, e.g. instruction fetch on port 0 and data access on port 1.
- Arbitrates round-robin, registers the winning access onto the RAM pins and returns read data with a valid strobe.
- A lock input lets one requester hold the RAM across several accesses for read-modify-write sequences.

Parameters:
- WORD, `DefaultWordSize: data width.
- ADDR, `DefaultAddrSize: address width.

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset_n  input  1  synchronous, active-low reset.
- req0, req1  input  1  access request; held with we/addr/wdata stable until gnt is seen high.
- we0, we1  input  1  1 = write, 0 = read.
- lock0, lock1  input  1  keep ownership after this access.
- addr0, addr1  input  ADDR  access address.
- wdata0, wdata1  input  WORD  write data.
- gnt0, gnt1  output  1  combinational; request accepted at this rising edge.
- rdata0, rdata1  output  WORD  registered read data.
- rvalid0, rvalid1  output  1  one-cycle pulse; rdata valid.
- ram_in  output  WORD  registered; drives ram `in`.
- ram_address  output  ADDR  registered; drives ram `address`.
- ram_load  output  1  registered; drives ram `load`.
- ram_value  input  WORD  from ram `value`.

Behaviour:
- Reset (reset_n=0 at posedge):
  - state=IDLE, last=1 (port 0 wins the first tie).
  - ram_load=0, ram_address=0, ram_in=0.
  - rdata0/1=0, rvalid0/1=0.
  - gnt0/1 forced 0 while reset_n=0.
- Timing per access, accepted in cycle N (gnt_i=1):
  - Edge ending N: ram_address<=addr_i, ram_in<=wdata_i, ram_load<=we_i; the port tag and a read flag are registered.
  - Cycle N+1: the RAM performs the access. A write commits at the edge ending N+1. For a read, rdata_i<=ram_value at that edge.
  - Read result: rvalid_i=1 for exactly cycle N+2.
  - Throughput: one access per cycle; back-to-back grants are allowed.
- Idle cycles: no grant means ram_load<=0. ram_address and ram_in hold their values.
- Read-after-write: a read of the same address granted in N+1 returns the new data.
- Only the accessing port gets rvalid. rdata of the other port holds its value.
- Arbitration (state IDLE):
  - Only one request: that port is granted.
  - Both requests: the port != last is granted.
  - On every grant, last<=granted port.
- FSM states: IDLE, LOCK0, LOCK1.
  - IDLE -> LOCKi when port i is granted with lock_i=1.
  - LOCKi: only port i may be granted, and the other port stalls with gnt=0. last is unchanged.
  - LOCKi -> IDLE when port i is granted with lock_i=0 (this is the final access of the sequence).
  - LOCKi -> IDLE when req_i=0 and lock_i=0 (release with no access).
  - LOCKi with req_i=0 and lock_i=1: stay in LOCKi; no grant to either port.
  - In IDLE, a lock input is ignored unless that port is granted.
- Reset mid-operation:
  - A write already on ram_load in the cycle reset is sampled still commits, because the RAM has no reset.
  - No rvalid is produced for an in-flight read.
  - Lock state is cleared.
- Each gnt must not depend on its own port's rvalid; no combinational path runs from ram_value to gnt.

Decomposition:
- Add to const.h:
  - state encodings `ArbIdle, `ArbLock0, `ArbLock1 (2 bits).
  - `ArbPorts = 2.
- Sub-module rr_arb2: combinational two-way round-robin pick. Inputs: req0, req1, last, state. Outputs: gnt0, gnt1. The FSM, issue registers and return path stay in ram_arbiter.

Test Plan:
- Reset, then port 0 writes 3 @ addr 0 -> gnt0 in cycle 1; ram_load=1, ram_address=0, ram_in=3 in cycle 2; no rvalid.
- Port 0 writes 7 @ addr 1, then port 1 reads addr 1 the next cycle -> rdata1=7 with rvalid1 a single pulse two cycles after gnt1.
- req0 and req1 both held for 4 cycles, all reads -> grants alternate 0,1,0,1; ram_load=0 throughout.
- Port 1 with lock1=1 does read addr 2 then write 9 @ addr 2 with lock1=0; req0 held throughout -> gnt0=0 until after the write grant, then gnt0=1; a final read of addr 2 returns 9.
- Port 0 granted a write of 5 @ addr 3 with lock0=1, then reset_n=0 for one cycle -> the write still commits (a later read of addr 3 returns 5); state IDLE, rvalid0/1=0, ram_load=0 after the reset edge.
- LOCK0 with req0=0 and lock0=1 for 3 cycles, req1=1 -> no grants; lock0 drops -> gnt1 the next cycle.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// ============================================================================
// ram_arbiter_pkg : shared sizes, FSM encodings and issue tag for ram_arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

package ram_arbiter_pkg;

    localparam int DEFAULT_WORD_SIZE = 16;
    localparam int DEFAULT_ADDR_SIZE = 8;
    localparam int ARB_PORTS         = 2;

    localparam logic [1:0] ARB_IDLE  = 2'b00;
    localparam logic [1:0] ARB_LOCK0 = 2'b01;
    localparam logic [1:0] ARB_LOCK1 = 2'b10;

    // Travels with an access from issue to the read-return stage.
    typedef struct packed {
        logic port;
        logic rd;
    } arb_tag_t;

endpackage

`default_nettype wire

// File: rtl/ram_arbiter_rr_arb2.sv
// ============================================================================
// rr_arb2 : combinational two-way round-robin pick, honouring a held lock
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_arb2
    import ram_arbiter_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
    input  logic       last,
    input  logic [1:0] state,
    output logic       gnt0,
    output logic       gnt1
);

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (state)
            ARB_LOCK0: gnt0 = req0;
            ARB_LOCK1: gnt1 = req1;
            default: begin
                // On a tie the port that did not win last time goes first.
                gnt0 = req0 & (~req1 | last);
                gnt1 = req1 & (~req0 | ~last);
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ============================================================================
// ram_arbiter : two-port round-robin arbiter and sequencer for a single-port RAM
// Revision: 1.0
// ============================================================================
`default_nettype none

module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int WORD = DEFAULT_WORD_SIZE,
    parameter int ADDR = DEFAULT_ADDR_SIZE
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req0,
    input  logic            req1,
    input  logic            we0,
    input  logic            we1,
    input  logic            lock0,
    input  logic            lock1,
    input  logic [ADDR-1:0] addr0,
    input  logic [ADDR-1:0] addr1,
    input  logic [WORD-1:0] wdata0,
    input  logic [WORD-1:0] wdata1,
    output logic            gnt0,
    output logic            gnt1,
    output logic [WORD-1:0] rdata0,
    output logic [WORD-1:0] rdata1,
    output logic            rvalid0,
    output logic            rvalid1,
    output logic [WORD-1:0] ram_in,
    output logic [ADDR-1:0] ram_address,
    output logic            ram_load,
    input  logic [WORD-1:0] ram_value
);

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic            r_last;
    logic            w_pick0;
    logic            w_pick1;
    logic            w_any;
    arb_tag_t        r_tag;
    logic [ADDR-1:0] r_ram_address;
    logic [WORD-1:0] r_ram_in;
    logic            r_ram_load;
    logic [WORD-1:0] r_rdata0;
    logic [WORD-1:0] r_rdata1;
    logic            r_rvalid0;
    logic            r_rvalid1;

    rr_arb2 u_rr_arb2 (
        .req0  (req0),
        .req1  (req1),
        .last  (r_last),
        .state (r_state),
        .gnt0  (w_pick0),
        .gnt1  (w_pick1)
    );

    assign gnt0  = w_pick0 & reset_n;
    assign gnt1  = w_pick1 & reset_n;
    assign w_any = gnt0 | gnt1;

    // In LOCKi the grant equals req_i, so dropping lock_i always ends the
    // sequence: either as the final access or as a release without access.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (gnt0 && lock0) begin
                    w_state_nxt = ARB_LOCK0;
                end else if (gnt1 && lock1) begin
                    w_state_nxt = ARB_LOCK1;
                end
            end
            ARB_LOCK0: if (!lock0) w_state_nxt = ARB_IDLE;
            ARB_LOCK1: if (!lock1) w_state_nxt = ARB_IDLE;
            default:   w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= ARB_IDLE;
            r_last        <= 1'b1;
            r_tag         <= '0;
            r_ram_address <= '0;
            r_ram_in      <= '0;
            r_ram_load    <= 1'b0;
            r_rdata0      <= '0;
            r_rdata1      <= '0;
            r_rvalid0     <= 1'b0;
            r_rvalid1     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_any && r_state == ARB_IDLE) begin
                r_last <= gnt1;
            end

            if (w_any) begin
                r_ram_address <= gnt1 ? addr1 : addr0;
                r_ram_in      <= gnt1 ? wdata1 : wdata0;
                r_ram_load    <= gnt1 ? we1 : we0;
                r_tag.port    <= gnt1;
                r_tag.rd      <= gnt1 ? ~we1 : ~we0;
            end else begin
                r_ram_load    <= 1'b0;
                r_tag.rd      <= 1'b0;
            end

            // The RAM read happens in the cycle after issue; capture it here.
            r_rvalid0 <= r_tag.rd & ~r_tag.port;
            r_rvalid1 <= r_tag.rd &  r_tag.port;
            if (r_tag.rd && !r_tag.port) begin
                r_rdata0 <= ram_value;
            end
            if (r_tag.rd && r_tag.port) begin
                r_rdata1 <= ram_value;
            end
        end
    end

    assign ram_address = r_ram_address;
    assign ram_in      = r_ram_in;
    assign ram_load    = r_ram_load;
    assign rdata0      = r_rdata0;
    assign rdata1      = r_rdata1;
    assign rvalid0     = r_rvalid0;
    assign rvalid1     = r_rvalid1;

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// ============================================================================
// tb_ram_arbiter : directed and randomized checks of ram_arbiter with a RAM
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ram_arbiter;

    localparam int W = 8;
    localparam int A = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         req0, req1, we0, we1, lock0, lock1;
    logic [A-1:0] addr0, addr1;
    logic [W-1:0] wdata0, wdata1;
    logic         gnt0, gnt1;
    logic [W-1:0] rdata0, rdata1;
    logic         rvalid0, rvalid1;
    logic [W-1:0] ram_in;
    logic [A-1:0] ram_address;
    logic         ram_load;
    logic [W-1:0] ram_value;

    always #5 clk = ~clk;

    ram_arbiter #(.WORD(W), .ADDR(A)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rdata0(rdata0), .rdata1(rdata1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .ram_in(ram_in), .ram_address(ram_address), .ram_load(ram_load),
        .ram_value(ram_value)
    );

    // Single-port RAM: combinational read, write on posedge when load=1.
    logic [W-1:0] mem [1<<A];
    logic         ram_clear;
    assign ram_value = mem[ram_address];
    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < (1<<A); i++) mem[i] <= '0;
        end else if (ram_load) begin
            mem[ram_address] <= ram_in;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int           due;
        int           port;
        logic [W-1:0] data;
    } ev_t;

    ev_t          q[$];
    logic [W-1:0] m_mem [1<<A];
    int           m_owner = -1;   // -1: free, else port holding the lock
    int           m_last  = 1;
    logic [A-1:0] m_addr  = '0;
    logic [W-1:0] m_in    = '0;
    logic         m_load  = 1'b0;
    logic [W-1:0] m_rdata [2];
    logic         m_g0 = 1'b0, m_g1 = 1'b0;

    initial begin
        for (int i = 0; i < (1<<A); i++) m_mem[i] = '0;
        m_rdata[0] = '0;
        m_rdata[1] = '0;
    end

    function automatic int model_grant();
        if (!reset_n) return -1;
        if (m_owner == 0) return req0 ? 0 : -1;
        if (m_owner == 1) return req1 ? 1 : -1;
        if (req0 && req1) return (m_last == 0) ? 1 : 0;
        if (req0) return 0;
        if (req1) return 1;
        return -1;
    endfunction

    always @(negedge clk) begin
        int           g;
        logic         e_rv [2];
        logic         lk, we;
        logic [A-1:0] ad;
        logic [W-1:0] wd;
        cyc++;
        e_rv[0] = 1'b0;
        e_rv[1] = 1'b0;
        while (q.size() > 0 && q[0].due <= cyc) begin
            if (q[0].due == cyc) begin
                e_rv[q[0].port]    = 1'b1;
                m_rdata[q[0].port] = q[0].data;
            end
            void'(q.pop_front());
        end
        g = model_grant();
        check("gnt0", gnt0, (g == 0));
        check("gnt1", gnt1, (g == 1));
        check("rvalid0", rvalid0, e_rv[0]);
        check("rvalid1", rvalid1, e_rv[1]);
        check("rdata0", rdata0, m_rdata[0]);
        check("rdata1", rdata1, m_rdata[1]);
        check("ram_load", ram_load, m_load);
        check("ram_address", ram_address, m_addr);
        check("ram_in", ram_in, m_in);
        m_g0 = (g == 0);
        m_g1 = (g == 1);
        if (!reset_n) begin
            m_owner = -1; m_last = 1;
            m_addr = '0; m_in = '0; m_load = 1'b0;
            m_rdata[0] = '0; m_rdata[1] = '0;
            q.delete();
        end else if (g >= 0) begin
            we = g ? we1 : we0;
            lk = g ? lock1 : lock0;
            ad = g ? addr1 : addr0;
            wd = g ? wdata1 : wdata0;
            m_addr = ad; m_in = wd; m_load = we;
            if (we) m_mem[ad] = wd;
            else q.push_back('{due: cyc + 2, port: g, data: m_mem[ad]});
            if (m_owner < 0) begin
                m_last = g;
                if (lk) m_owner = g;
            end else if (!lk) begin
                m_owner = -1;
            end
        end else begin
            m_load = 1'b0;
            if (m_owner == 0 && !req0 && !lock0) m_owner = -1;
            if (m_owner == 1 && !req1 && !lock1) m_owner = -1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic p0(input logic r, input logic w, input logic l, input int a, input int d);
        req0 = r; we0 = w; lock0 = l; addr0 = A'(a); wdata0 = W'(d);
    endtask

    task automatic p1(input logic r, input logic w, input logic l, input int a, input int d);
        req1 = r; we1 = w; lock1 = l; addr1 = A'(a); wdata1 = W'(d);
    endtask

    task automatic rand_port(input int p, input logic granted, inout logic r,
                             inout logic w, inout logic l, inout logic [A-1:0] a,
                             inout logic [W-1:0] d);
        if (r && !granted) return;
        if ($urandom_range(0, 9) < 5) begin
            r = 1'b1;
            w = $urandom_range(0, 1) == 1;
            l = $urandom_range(0, 5) == 0;
            a = A'($urandom_range(0, (1<<A) - 1));
            d = W'($urandom);
        end else begin
            r = 1'b0;
            l = (m_owner == p) ? ($urandom_range(0, 1) == 1) : 1'b0;
        end
    endtask

    initial begin
        reset_n = 1'b0; ram_clear = 1'b1;
        p0(0, 0, 0, 0, 0);
        p1(0, 0, 0, 0, 0);
        repeat (2) tick();
        reset_n = 1'b1; ram_clear = 1'b0;

        // port 0 write 3 @ 0
        p0(1, 1, 0, 0, 3); #1;
        check("t1_gnt0", gnt0, 1);
        tick(); p0(0, 0, 0, 0, 0); #1;
        check("t1_ram_load", ram_load, 1);
        check("t1_ram_address", ram_address, 0);
        check("t1_ram_in", ram_in, 3);
        check("t1_rvalid0", rvalid0, 0);

        // port 0 writes 7 @ 1, port 1 reads it back next cycle
        p0(1, 1, 0, 1, 7);
        tick(); p0(0, 0, 0, 0, 0); p1(1, 0, 0, 1, 0); #1;
        check("t2_gnt1", gnt1, 1);
        tick(); p1(0, 0, 0, 0, 0); #1;
        check("t2_rvalid1_early", rvalid1, 0);
        tick(); #1;
        check("t2_rvalid1", rvalid1, 1);
        check("t2_rdata1", rdata1, 7);
        tick(); #1;
        check("t2_rvalid1_pulse", rvalid1, 0);

        // both ports read for 4 cycles: alternating grants
        p0(1, 0, 0, 4, 0); p1(1, 0, 0, 5, 0);
        for (int k = 0; k < 4; k++) begin
            #1;
            check("t3_gnt0", gnt0, (k % 2) == 0);
            check("t3_gnt1", gnt1, (k % 2) == 1);
            check("t3_ram_load", ram_load, 0);
            tick();
        end
        p1(0, 0, 0, 0, 0);
        tick(); p0(0, 0, 0, 0, 0);   // port 0 alone: last becomes 0

        // port 1 locked read-modify-write of addr 2 while port 0 waits
        p1(1, 0, 1, 2, 0); p0(1, 0, 0, 6, 0); #1;
        check("t4_gnt1_a", gnt1, 1);
        check("t4_gnt0_a", gnt0, 0);
        tick(); p1(1, 1, 0, 2, 9); #1;
        check("t4_gnt1_b", gnt1, 1);
        check("t4_gnt0_b", gnt0, 0);
        tick(); p1(0, 0, 0, 0, 0); #1;
        check("t4_gnt0_c", gnt0, 1);
        tick(); p0(0, 0, 0, 0, 0); p1(1, 0, 0, 2, 0);
        tick(); p1(0, 0, 0, 0, 0);
        tick(); #1;
        check("t4_rvalid1", rvalid1, 1);
        check("t4_rdata1", rdata1, 9);

        // locked write of 5 @ 3 interrupted by reset
        p0(1, 1, 1, 3, 5);
        tick(); p0(1, 0, 1, 3, 0); reset_n = 1'b0; #1;
        check("t5_gnt0_rst", gnt0, 0);
        tick(); reset_n = 1'b1; p0(0, 0, 0, 0, 0); p1(1, 0, 0, 3, 0); #1;
        check("t5_ram_load", ram_load, 0);
        check("t5_rvalid0", rvalid0, 0);
        check("t5_rvalid1", rvalid1, 0);
        check("t5_gnt1_idle", gnt1, 1);
        tick(); p1(0, 0, 0, 0, 0);
        tick(); #1;
        check("t5_rdata1", rdata1, 5);

        // LOCK0 held idle while port 1 waits
        p0(1, 0, 1, 0, 0);
        tick(); p0(0, 0, 1, 0, 0); p1(1, 0, 0, 1, 0);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("t6_gnt0_hold", gnt0, 0);
            check("t6_gnt1_hold", gnt1, 0);
            tick();
        end
        lock0 = 1'b0; #1;
        check("t6_gnt1_release", gnt1, 0);
        tick(); #1;
        check("t6_gnt1_after", gnt1, 1);
        tick(); p1(0, 0, 0, 0, 0);
        tick();

        // randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            reset_n = ($urandom_range(0, 199) != 0);
            rand_port(0, m_g0, req0, we0, lock0, addr0, wdata0);
            rand_port(1, m_g1, req1, we1, lock1, addr1, wdata1);
            tick();
        end
        p0(0, 0, 0, 0, 0); p1(0, 0, 0, 0, 0);
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
